// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares the FIFO write port among N_REQ valid/ready
// requesters, granting one owner at a time for a burst of up to MAX_BURST beats.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  parameter int STALL_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  output logic [N_REQ-1:0]           req_ready,
  input  logic                       fifo_full,
  output logic                       fifo_wr_en,
  output logic [DATA_W-1:0]          fifo_wr_data,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic [STALL_W-1:0]         stall_cnt
);

  localparam int ID_W   = $clog2(N_REQ);
  localparam int BEAT_W = $clog2(MAX_BURST + 1);

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("fifo_wr_arbiter: N_REQ must be 2..8");
  end
  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
    $error("fifo_wr_arbiter: MAX_BURST must be 1..15");
  end

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t              state, state_nxt;
  logic [ID_W-1:0]     owner, owner_nxt;
  logic [ID_W-1:0]     ptr, ptr_nxt;
  logic [BEAT_W-1:0]   beat_cnt, beat_cnt_nxt;
  logic [STALL_W-1:0]  stall_q, stall_nxt;

  logic                owner_valid;
  logic [DATA_W-1:0]   owner_data;
  logic                pick_found;
  logic [ID_W-1:0]     pick_idx;
  logic [ID_W-1:0]     cand;

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
    return (v == ID_W'(N_REQ - 1)) ? '0 : v + 1'b1;
  endfunction

  always_comb begin
    owner_valid = 1'b0;
    owner_data  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (owner == ID_W'(i)) begin
        owner_valid = req_valid[i];
        owner_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Rotating first-set search starting at ptr, wrapping modulo N_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = ptr;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  // Reset masks the outputs combinationally so no beat is accepted mid-reset.
  always_comb begin
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    busy         = 1'b0;
    grant_id     = owner;
    if (rst) begin
      grant_id = '0;
    end else if (state == GRANT) begin
      req_ready[owner] = !fifo_full;
      fifo_wr_en       = owner_valid && !fifo_full;
      fifo_wr_data     = owner_data;
      busy             = 1'b1;
    end
  end

  assign stall_cnt = stall_q;

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    ptr_nxt      = ptr;
    beat_cnt_nxt = beat_cnt;
    stall_nxt    = stall_q;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt    = GRANT;
          owner_nxt    = pick_idx;
          beat_cnt_nxt = '0;
        end
      end
      GRANT: begin
        if (!owner_valid) begin
          state_nxt = IDLE;
          ptr_nxt   = wrap_inc(owner);
        end else if (fifo_full) begin
          if (stall_q != '1) begin
            stall_nxt = stall_q + 1'b1;
          end
        end else if (beat_cnt == BEAT_W'(MAX_BURST - 1)) begin
          state_nxt    = IDLE;
          ptr_nxt      = wrap_inc(owner);
          beat_cnt_nxt = beat_cnt + 1'b1;
        end else begin
          beat_cnt_nxt = beat_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
      stall_q  <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      ptr      <= ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
      stall_q  <= stall_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, directed corner cases
// and randomized traffic against a behavioural grant/burst model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic            fifo_full;
  logic [N-1:0]    req_ready;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_wr_data;
  logic [1:0]      grant_id;
  logic            busy;
  logic [15:0]     stall_cnt;

  logic [N-1:0]    rdy4;
  logic            wr4;
  logic [DW-1:0]   wd4;
  logic [1:0]      gid4;
  logic            busy4;
  logic [3:0]      stall4;

  fifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(MB), .STALL_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .grant_id(grant_id), .busy(busy),
    .stall_cnt(stall_cnt)
  );

  fifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(MB), .STALL_W(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rdy4), .fifo_full(fifo_full), .fifo_wr_en(wr4),
    .fifo_wr_data(wd4), .grant_id(gid4), .busy(busy4), .stall_cnt(stall4)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: owner (-1 when idle), beats moved in this grant,
  // next round-robin start, last owner and the two stall counters.
  int m_owner = -1;
  int m_gid   = 0;
  int m_next  = 0;
  int m_beats = 0;
  int m_stall = 0;
  int m_stall4 = 0;

  logic [N-1:0]  e_ready;
  logic          e_wr;
  logic [DW-1:0] e_data;
  logic [1:0]    e_gid;
  logic          e_busy;
  logic [N-1:0]  last_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_eval();
    e_ready = '0;
    e_wr    = 1'b0;
    e_data  = '0;
    e_gid   = '0;
    e_busy  = 1'b0;
    if (!rst) begin
      e_gid = 2'(m_gid);
      if (m_owner >= 0) begin
        e_busy = 1'b1;
        e_data = req_data[m_owner*DW +: DW];
        if (!fifo_full) begin
          e_ready[m_owner] = 1'b1;
          e_wr = req_valid[m_owner];
        end
      end
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_owner = -1; m_gid = 0; m_next = 0; m_beats = 0; m_stall = 0; m_stall4 = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_next + k) % N;
        if (req_valid[c]) begin
          m_owner = c; m_gid = c; m_beats = 0;
          break;
        end
      end
    end else if (!req_valid[m_owner]) begin
      m_next = (m_owner + 1) % N; m_owner = -1;
    end else if (fifo_full) begin
      if (m_stall < 65535) m_stall++;
      if (m_stall4 < 15) m_stall4++;
    end else begin
      m_beats++;
      if (m_beats == MB) begin
        m_next = (m_owner + 1) % N; m_owner = -1;
      end
    end
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic apply(input string tag);
    #1;
    model_eval();
    chk({tag, ".ready"}, 64'(req_ready), 64'(e_ready));
    chk({tag, ".wr_en"}, 64'(fifo_wr_en), 64'(e_wr));
    chk({tag, ".wr_data"}, 64'(fifo_wr_data), 64'(e_data));
    chk({tag, ".grant_id"}, 64'(grant_id), 64'(e_gid));
    chk({tag, ".busy"}, 64'(busy), 64'(e_busy));
    if (!rst) begin
      chk({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
      chk({tag, ".stall4"}, 64'(stall4), 64'(m_stall4));
    end
    last_acc = e_ready & req_valid;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; fifo_full = 1'b0;
    apply("reset");
    rst = 1'b0;
  endtask

  typedef struct {
    logic          rst;
    logic [N-1:0]  valid;
    logic [31:0]   data;
    logic          full;
    logic [N-1:0]  ready;
    logic          wr;
    logic [DW-1:0] wdata;
    logic [1:0]    gid;
    logic          busy;
  } vec_t;

  vec_t tv[14];
  int   grants[$];
  int   nwr;
  logic [15:0] s0;
  logic [DW-1:0] dctr[N];

  initial begin
    tv[0]  = '{1'b1, 4'b0000, 32'h0,    1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
    tv[1]  = '{1'b0, 4'b0001, 32'h10,   1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
    tv[2]  = '{1'b0, 4'b0001, 32'h10,   1'b0, 4'b0001, 1'b1, 8'h10, 2'd0, 1'b1};
    tv[3]  = '{1'b0, 4'b0001, 32'h11,   1'b0, 4'b0001, 1'b1, 8'h11, 2'd0, 1'b1};
    tv[4]  = '{1'b0, 4'b0001, 32'h12,   1'b0, 4'b0001, 1'b1, 8'h12, 2'd0, 1'b1};
    tv[5]  = '{1'b0, 4'b0001, 32'h13,   1'b0, 4'b0001, 1'b1, 8'h13, 2'd0, 1'b1};
    tv[6]  = '{1'b0, 4'b0001, 32'h14,   1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
    tv[7]  = '{1'b0, 4'b0001, 32'h14,   1'b0, 4'b0001, 1'b1, 8'h14, 2'd0, 1'b1};
    tv[8]  = '{1'b0, 4'b0001, 32'h15,   1'b0, 4'b0001, 1'b1, 8'h15, 2'd0, 1'b1};
    tv[9]  = '{1'b0, 4'b0000, 32'h15,   1'b0, 4'b0001, 1'b0, 8'h15, 2'd0, 1'b1};
    tv[10] = '{1'b0, 4'b0000, 32'h0,    1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
    tv[11] = '{1'b0, 4'b0010, 32'hAB00, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
    tv[12] = '{1'b0, 4'b0010, 32'hAB00, 1'b1, 4'b0000, 1'b0, 8'hAB, 2'd1, 1'b1};
    tv[13] = '{1'b0, 4'b0010, 32'hAB00, 1'b0, 4'b0010, 1'b1, 8'hAB, 2'd1, 1'b1};

    rst = 1'b1; req_valid = '0; req_data = '0; fifo_full = 1'b0;
    @(negedge clk);

    // Vector table: burst limit on req0, valid drop, then req1 with a full cycle.
    for (int i = 0; i < 14; i++) begin
      rst = tv[i].rst; req_valid = tv[i].valid; req_data = tv[i].data; fifo_full = tv[i].full;
      #1;
      chk($sformatf("tv%0d.ready", i), 64'(req_ready), 64'(tv[i].ready));
      chk($sformatf("tv%0d.wr_en", i), 64'(fifo_wr_en), 64'(tv[i].wr));
      chk($sformatf("tv%0d.wr_data", i), 64'(fifo_wr_data), 64'(tv[i].wdata));
      chk($sformatf("tv%0d.grant_id", i), 64'(grant_id), 64'(tv[i].gid));
      chk($sformatf("tv%0d.busy", i), 64'(busy), 64'(tv[i].busy));
      apply($sformatf("tv%0d", i));
    end

    // Round robin with all four requesters valid.
    do_reset();
    req_valid = '1; req_data = 32'h33221100;
    nwr = 0;
    for (int i = 0; i < 24; i++) begin
      logic pb;
      pb = busy;
      #1 if (fifo_wr_en) nwr++;
      apply("rr");
      if (busy && !pb) grants.push_back(int'(grant_id));
    end
    chk("rr.num_grants", 64'(grants.size()), 64'd5);
    for (int i = 0; i < 5 && i < grants.size(); i++)
      chk($sformatf("rr.grant%0d", i), 64'(grants[i]), 64'(i % N));
    chk("rr.writes", 64'(nwr), 64'd19);

    // Full stall during beat 2 of req2.
    do_reset();
    req_valid = 4'b0100; req_data = 32'h002A0000;
    nwr = 0;
    for (int i = 0; i < 10; i++) begin
      fifo_full = (i >= 3 && i < 8);
      if (i == 3) s0 = stall_cnt;
      #1 if (fifo_wr_en) nwr++;
      apply("stall");
    end
    chk("stall.delta", 64'(stall_cnt - s0), 64'd5);
    chk("stall.writes", 64'(nwr), 64'd4);
    chk("stall.released", 64'(busy), 64'd0);
    chk("stall.grant_id", 64'(grant_id), 64'd2);

    // Valid drop: req1 sends 2 beats, then req0 and req3 become valid.
    do_reset();
    req_valid = 4'b0010; req_data = 32'h00005A00;
    repeat (3) apply("drop");
    req_valid = 4'b1001;
    #1 chk("drop.no_write", 64'(fifo_wr_en), 64'd0);
    apply("drop");
    apply("drop");
    chk("drop.next_owner", 64'(grant_id), 64'd3);
    chk("drop.busy", 64'(busy), 64'd1);

    // Reset during beat 1 of req3, after one stalled cycle.
    do_reset();
    req_valid = 4'b1000; req_data = 32'h77000000;
    apply("rmid");
    fifo_full = 1'b1;
    apply("rmid");
    fifo_full = 1'b0;
    apply("rmid");
    rst = 1'b1;
    #1 chk("rmid.wr_in_reset", 64'(fifo_wr_en), 64'd0);
    apply("rmid");
    rst = 1'b0; req_valid = 4'b1001;
    chk("rmid.busy", 64'(busy), 64'd0);
    chk("rmid.grant_id", 64'(grant_id), 64'd0);
    chk("rmid.stall", 64'(stall_cnt), 64'd0);
    apply("rmid");
    chk("rmid.first_grant", 64'(grant_id), 64'd0);
    chk("rmid.granted", 64'(busy), 64'd1);

    // Saturation of the 4-bit stall counter.
    do_reset();
    req_valid = 4'b0001; req_data = 32'h5;
    apply("sat");
    fifo_full = 1'b1;
    repeat (20) apply("sat");
    chk("sat.stall4", 64'(stall4), 64'd15);
    chk("sat.stall16", 64'(stall_cnt), 64'd20);
    repeat (2) apply("sat");
    chk("sat.stall4_hold", 64'(stall4), 64'd15);
    fifo_full = 1'b0;

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < N; i++) dctr[i] = DW'(i * 40);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(0, 9) < 7);
        req_data[i*DW +: DW] = dctr[i];
      end
      fifo_full = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 299) == 0);
      apply("rand");
      for (int i = 0; i < N; i++) if (last_acc[i]) dctr[i] = dctr[i] + 1'b1;
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
